// File: rtl/dsp48a1_mac_sequencer.sv
// dsp48a1_mac_sequencer
// Runs unsigned dot-product jobs on one DSP48A1 slice (A1/B1/M/OPMODE/P
// registered). Each job clears P, streams len operand pairs into A/B,
// and steers OPMODE one cycle behind each accepted pair so that P only
// ever adds real products. The 48-bit sum is returned on a held result
// handshake.
//
// Ports
//   CLK, RST_N            clock, synchronous active-low reset
//   start, len, busy      job request / length / activity flag
//   s_valid, s_ready,
//   s_a, s_b              operand pair stream (18-bit unsigned)
//   dsp_a, dsp_b          slice A/B inputs
//   dsp_opmode            slice OPMODE input
//   dsp_ce*               slice clock enables
//   dsp_rstp              slice P reset (active-high)
//   dsp_p                 slice P output
//   res_valid, res_ready,
//   res_data              result handshake and 48-bit sum
//
// state  | meaning
// IDLE   | waiting for start, slice disabled
// CLEAR  | one cycle of RSTP to zero P
// FEED   | accepting operand pairs until len have been taken
// DRAIN  | three cycles for the last product to reach P
// DONE   | result held until res_ready

module dsp48a1_mac_sequencer #(
  parameter int LEN_W = 12
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_ceopmode,
  output logic             dsp_cep,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_inc;
  logic [1:0]       drain_cnt;
  logic             tag;
  logic             hs;
  logic             active;

  assign s_ready   = (state == ST_FEED);
  assign hs        = s_valid && s_ready;
  assign count_inc = count + LEN_W'(1);
  assign active    = (state == ST_CLEAR) || (state == ST_FEED) || (state == ST_DRAIN);

  // Operands are zeroed on bubbles; OPMODE X=0 on the matching cycle
  // keeps whatever M captures out of P anyway.
  assign dsp_a = hs ? s_a : 18'd0;
  assign dsp_b = hs ? s_b : 18'd0;

  // tag lines up with the cycle the pair sits in A1/B1, so the registered
  // OPMODE is 09 exactly when M holds a real product.
  assign dsp_opmode   = active ? (tag ? 8'h09 : 8'h08) : 8'h00;
  assign dsp_cea      = active;
  assign dsp_ceb      = active;
  assign dsp_cem      = active;
  assign dsp_ceopmode = active;
  assign dsp_cep      = active;
  assign dsp_rstp     = (state == ST_CLEAR);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      count     <= '0;
      drain_cnt <= '0;
      tag       <= 1'b0;
      res_data  <= '0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tag <= hs;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            count <= '0;
            busy  <= 1'b1;
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (len_q != '0) begin
            state <= ST_FEED;
          end else begin
            drain_cnt <= 2'd2;
            state     <= ST_DRAIN;
          end
        end
        ST_FEED: begin
          if (hs) begin
            count <= count_inc;
            if (count_inc == len_q) begin
              drain_cnt <= 2'd2;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 2'd0) begin
            res_data  <= dsp_p;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1/M/OPMODE/P registered, unsigned). Job sums are computed from the
// operand tables and queued at job start; they are popped when res_valid
// appears.

module tb_dsp48a1_mac_sequencer;

  localparam int LEN_W = 12;

  logic             CLK;
  logic             RST_N;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a, s_b;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp;
  logic [47:0]      dsp_p;
  logic             res_valid;
  logic             res_ready;
  logic [47:0]      res_data;

  dsp48a1_mac_sequencer #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .len(len), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb), .dsp_cem(dsp_cem),
    .dsp_ceopmode(dsp_ceopmode), .dsp_cep(dsp_cep), .dsp_rstp(dsp_rstp),
    .dsp_p(dsp_p), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // slice model
  logic [17:0] a1_q, b1_q;
  logic [35:0] m_q;
  logic [7:0]  op_q;
  logic [47:0] p_q;
  logic [47:0] x_mux, z_mux;

  assign x_mux = (op_q[1:0] == 2'b01) ? {12'd0, m_q} : 48'd0;
  assign z_mux = (op_q[3:2] == 2'b10) ? p_q : 48'd0;
  assign dsp_p = p_q;

  initial begin
    a1_q = '0; b1_q = '0; m_q = '0; op_q = '0; p_q = '0;
  end

  always @(posedge CLK) begin
    if (dsp_cea) a1_q <= dsp_a;
    if (dsp_ceb) b1_q <= dsp_b;
    if (dsp_cem) m_q <= a1_q * b1_q;
    if (dsp_ceopmode) op_q <= dsp_opmode;
    if (dsp_rstp) p_q <= '0;
    else if (dsp_cep) p_q <= z_mux + x_mux;
  end

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [47:0] exp_q[$];
  logic [17:0] pa[8];
  logic [17:0] pb[8];
  logic        saw_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic feed_pair(input logic [17:0] a, input logic [17:0] b);
    logic acc;
    int   g;
    acc = 1'b0;
    g = 0;
    s_valid = 1'b1;
    s_a = a;
    s_b = b;
    while (!acc && g < 50) begin
      @(negedge CLK);
      if (s_ready) begin
        acc = 1'b1;
        chk("dsp_a_pass", 64'(dsp_a), 64'(a));
        chk("dsp_b_pass", 64'(dsp_b), 64'(b));
      end
      next_cyc();
      g++;
    end
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
  endtask

  task automatic run_job(input int n, input int bub, input int exp_lat);
    logic [47:0] sum;
    logic [47:0] exp;
    int unsigned t0;
    int unsigned lat;
    logic got;
    int g;
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + 48'(pa[i] * pb[i]);
    exp_q.push_back(sum);
    saw_ready = 1'b0;
    start = 1'b1;
    len = LEN_W'(n);
    t0 = cyc;
    next_cyc();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      feed_pair(pa[i], pb[i]);
      if (i != n - 1) repeat (bub) next_cyc();
    end
    got = 1'b0;
    g = 0;
    lat = 0;
    while (!got && g < 200) begin
      @(negedge CLK);
      if (s_ready) saw_ready = 1'b1;
      if (res_valid) begin
        got = 1'b1;
        lat = cyc - t0;
      end else begin
        next_cyc();
      end
      g++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hDEAD;
    chk("res_timeout", 64'(got), 64'd1);
    if (got) begin
      chk("res_data", 64'(res_data), 64'(exp));
      if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
      next_cyc();
      next_cyc();
      @(negedge CLK);
      chk("res_valid_hold", 64'(res_valid), 64'd1);
      chk("res_data_hold", 64'(res_data), 64'(exp));
      next_cyc();
      res_ready = 1'b1;
      next_cyc();
      res_ready = 1'b0;
      @(negedge CLK);
      chk("res_valid_drop", 64'(res_valid), 64'd0);
      chk("busy_drop", 64'(busy), 64'd0);
      next_cyc();
    end
  endtask

  initial begin
    RST_N = 1'b0;
    start = 1'b1;
    len = LEN_W'(5);
    s_valid = 1'b0;
    s_a = '0;
    s_b = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'd0);
    chk("rst_ces", 64'({dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp}), 64'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    start = 1'b0;
    next_cyc();

    // back-to-back len=3
    pa[0] = 18'd2; pb[0] = 18'd3;
    pa[1] = 18'd4; pb[1] = 18'd5;
    pa[2] = 18'd6; pb[2] = 18'd7;
    run_job(3, 0, 8);

    // bubbles between pairs
    pa[0] = 18'd1;    pb[0] = 18'd1;
    pa[1] = 18'd10;   pb[1] = 18'd10;
    pa[2] = 18'd100;  pb[2] = 18'd100;
    pa[3] = 18'd1000; pb[3] = 18'd1000;
    run_job(4, 2, -1);

    // full-scale operands, then a short job proving CLEAR wipes P
    pa[0] = 18'h3FFFF; pb[0] = 18'h3FFFF;
    pa[1] = 18'h3FFFF; pb[1] = 18'h3FFFF;
    run_job(2, 0, 7);
    pa[0] = 18'd5; pb[0] = 18'd5;
    run_job(1, 0, 6);

    // empty job
    run_job(0, 0, 5);
    chk("len0_no_ready", 64'(saw_ready), 64'd0);

    // reset mid-job
    start = 1'b1;
    len = LEN_W'(5);
    next_cyc();
    start = 1'b0;
    feed_pair(18'd11, 18'd12);
    feed_pair(18'd13, 18'd14);
    RST_N = 1'b0;
    next_cyc();
    RST_N = 1'b1;
    @(negedge CLK);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_s_ready", 64'(s_ready), 64'd0);
    chk("abort_opmode", 64'(dsp_opmode), 64'd0);
    chk("abort_cep", 64'(dsp_cep), 64'd0);
    chk("abort_res_data", 64'(res_data), 64'd0);
    next_cyc();
    pa[0] = 18'd7; pb[0] = 18'd9;
    run_job(1, 0, 6);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
